act_mem_loader: RTL and testbench

ACT_MEM_LOADER -- requirements
Module: act_mem_loader

---
 rtl/act_mem_loader.sv | 176 +++++++++++++++++
 tb/tb_act_mem_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_mem_loader.sv
// Activation memory loader: streams ENTRY_NUM*DIM*DIM words into (entry, y, x) slots.
// Optional macro ACT_LOADER_ABORT_EN adds an abort input that cancels a load in progress.
module act_mem_loader #(
    parameter int ENTRY_NUM = 1,
    parameter int DIM       = 1,
    parameter int DATA_SIZE = 64,
    parameter int IDX_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef ACT_LOADER_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 mem_write,
    output logic [IDX_W-1:0]     mem_index_entry,
    output logic [IDX_W-1:0]     mem_index_y,
    output logic [IDX_W-1:0]     mem_index_x,
    output logic [DATA_SIZE-1:0] mem_in_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] X_LAST   = IDX_W'(DIM - 1);
    localparam logic [IDX_W-1:0] E_LAST   = IDX_W'(ENTRY_NUM - 1);

    state_t                 state_r;
    logic [IDX_W-1:0]       ent_r;
    logic [IDX_W-1:0]       y_r;
    logic [IDX_W-1:0]       x_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   in_ready_r;
    logic                   mem_write_r;
    logic [IDX_W-1:0]       idx_e_r;
    logic [IDX_W-1:0]       idx_y_r;
    logic [IDX_W-1:0]       idx_x_r;
    logic [DATA_SIZE-1:0]   data_r;

    logic                   accept_s;
    logic                   x_last_s;
    logic                   y_last_s;
    logic                   last_s;
    logic                   abort_s;

    // Handshake and end-of-sweep decode from the current counters.
    always_comb begin
        accept_s = 1'b0;
        x_last_s = 1'b0;
        y_last_s = 1'b0;
        last_s   = 1'b0;
        abort_s  = 1'b0;
        accept_s = in_valid && in_ready_r;
        x_last_s = (x_r == X_LAST);
        y_last_s = (y_r == X_LAST);
        last_s   = x_last_s && y_last_s && (ent_r == E_LAST);
`ifdef ACT_LOADER_ABORT_EN
        abort_s  = abort && ((state_r == ST_LOAD) || (state_r == ST_FLUSH));
`else
        abort_s  = 1'b0;
`endif
    end

    // Loader FSM with registered handshake, status and memory-write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ent_r       <= IDX_ZERO;
            y_r         <= IDX_ZERO;
            x_r         <= IDX_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            mem_write_r <= 1'b0;
            idx_e_r     <= IDX_ZERO;
            idx_y_r     <= IDX_ZERO;
            idx_x_r     <= IDX_ZERO;
            data_r      <= {DATA_SIZE{1'b0}};
        end else begin
            // A word accepted in the abort cycle was already handshaken, so it is still written.
            mem_write_r <= accept_s;
            if (accept_s) begin
                idx_e_r <= ent_r;
                idx_y_r <= y_r;
                idx_x_r <= x_r;
                data_r  <= in_data;
            end

            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= ST_LOAD;
                        ent_r      <= IDX_ZERO;
                        y_r        <= IDX_ZERO;
                        x_r        <= IDX_ZERO;
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (abort_s) begin
                        state_r    <= ST_IDLE;
                        ent_r      <= IDX_ZERO;
                        y_r        <= IDX_ZERO;
                        x_r        <= IDX_ZERO;
                        busy_r     <= 1'b0;
                        in_ready_r <= 1'b0;
                    end else if (accept_s) begin
                        if (last_s) begin
                            state_r    <= ST_FLUSH;
                            in_ready_r <= 1'b0;
                        end else if (x_last_s) begin
                            x_r <= IDX_ZERO;
                            if (y_last_s) begin
                                y_r   <= IDX_ZERO;
                                ent_r <= ent_r + IDX_ONE;
                            end else begin
                                y_r <= y_r + IDX_ONE;
                            end
                        end else begin
                            x_r <= x_r + IDX_ONE;
                        end
                    end
                end
                ST_FLUSH: begin
                    busy_r <= 1'b0;
                    if (abort_s) begin
                        state_r <= ST_IDLE;
                        ent_r   <= IDX_ZERO;
                        y_r     <= IDX_ZERO;
                        x_r     <= IDX_ZERO;
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ent_r      <= IDX_ZERO;
                    y_r        <= IDX_ZERO;
                    x_r        <= IDX_ZERO;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign in_ready        = in_ready_r;
    assign mem_write       = mem_write_r;
    assign mem_index_entry = idx_e_r;
    assign mem_index_y     = idx_y_r;
    assign mem_index_x     = idx_x_r;
    assign mem_in_data     = data_r;

endmodule

// File: tb/tb_act_mem_loader.sv
// Directed bench for act_mem_loader: a 2x2x2 instance and a 1x1x1 instance.
// Abort scenario is included when ACT_LOADER_ABORT_EN is defined.
module tb_act_mem_loader;

    logic        clk;
    logic        rst_n;

    logic        a_start, a_busy, a_done, a_valid, a_ready, a_wr;
    logic [63:0] a_data, a_mdata;
    logic [7:0]  a_e, a_y, a_x;
`ifdef ACT_LOADER_ABORT_EN
    logic        a_abort;
    logic        b_abort;
`endif

    logic        b_start, b_busy, b_done, b_valid, b_ready, b_wr;
    logic [63:0] b_data, b_mdata;
    logic [7:0]  b_e, b_y, b_x;

    int          n_checks;
    int          n_errors;

    logic [23:0] a_idx_log [0:63];
    logic [63:0] a_dat_log [0:63];
    int          a_wr_n;
    int          a_done_n;
    int          b_wr_n;
    int          base;
    int          dbase;
    int          k;

    act_mem_loader #(.ENTRY_NUM(2), .DIM(2), .DATA_SIZE(64), .IDX_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
`ifdef ACT_LOADER_ABORT_EN
        .abort(a_abort),
`endif
        .busy(a_busy), .done(a_done), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .mem_write(a_wr), .mem_index_entry(a_e),
        .mem_index_y(a_y), .mem_index_x(a_x), .mem_in_data(a_mdata)
    );

    act_mem_loader #(.ENTRY_NUM(1), .DIM(1), .DATA_SIZE(64), .IDX_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
`ifdef ACT_LOADER_ABORT_EN
        .abort(b_abort),
`endif
        .busy(b_busy), .done(b_done), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .mem_write(b_wr), .mem_index_entry(b_e),
        .mem_index_y(b_y), .mem_index_x(b_x), .mem_in_data(b_mdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every memory write and done pulse away from the active edge.
    always @(negedge clk) begin
        if (a_wr && (a_wr_n < 64)) begin
            a_idx_log[a_wr_n] <= {a_e, a_y, a_x};
            a_dat_log[a_wr_n] <= a_mdata;
        end
        if (a_wr) a_wr_n <= a_wr_n + 1;
        if (a_done) a_done_n <= a_done_n + 1;
        if (b_wr) b_wr_n <= b_wr_n + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] idx_of(input int n);
        return {8'(n / 4), 8'((n / 2) % 2), 8'(n % 2)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        a_wr_n = 0; a_done_n = 0; b_wr_n = 0;
        a_start = 1'b0; a_valid = 1'b0; a_data = 64'h0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 64'h0;
`ifdef ACT_LOADER_ABORT_EN
        a_abort = 1'b0; b_abort = 1'b0;
`endif
        rst_n = 1'b0;
        #3;
        chk("rst_busy",  64'(a_busy), 64'h0);
        chk("rst_done",  64'(a_done), 64'h0);
        chk("rst_ready", 64'(a_ready), 64'h0);
        chk("rst_wr",    64'(a_wr), 64'h0);
        chk("rst_idx",   64'({a_e, a_y, a_x}), 64'h0);
        chk("rst_data",  a_mdata, 64'h0);
        chk("rst_b_ready", 64'(b_ready), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ready", 64'(a_ready), 64'h0);

        // Full load with in_valid held high.
        base = a_wr_n; dbase = a_done_n;
        a_start = 1'b1; step(); a_start = 1'b0;
        chk("t1_busy",  64'(a_busy), 64'h1);
        chk("t1_ready", 64'(a_ready), 64'h1);
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data = 64'h10 + 64'(i);
            step();
            chk("t1_wr",   64'(a_wr), 64'h1);
            chk("t1_idx",  64'({a_e, a_y, a_x}), 64'(idx_of(i)));
            chk("t1_data", a_mdata, 64'h10 + 64'(i));
        end
        chk("t1_flush_ready", 64'(a_ready), 64'h0);
        chk("t1_flush_busy",  64'(a_busy), 64'h1);
        chk("t1_flush_done",  64'(a_done), 64'h0);
        step();
        chk("t1_done",       64'(a_done), 64'h1);
        chk("t1_done_wr",    64'(a_wr), 64'h0);
        chk("t1_done_busy",  64'(a_busy), 64'h0);
        chk("t1_done_ready", 64'(a_ready), 64'h0);
        a_valid = 1'b0;
        step();
        chk("t1_post_done", 64'(a_done), 64'h0);
        chk("t1_post_busy", 64'(a_busy), 64'h0);
        step();
        chk("t1_nwr",   64'(a_wr_n - base), 64'd8);
        chk("t1_ndone", 64'(a_done_n - dbase), 64'd1);

        // in_valid alternating 1,0: writes only after accepts, outputs held on stalls.
        base = a_wr_n;
        a_start = 1'b1; step(); a_start = 1'b0;
        k = 0;
        for (int c = 0; c < 16; c++) begin
            a_valid = (c % 2 == 0);
            a_data  = 64'h20 + 64'(k);
            step();
            if (c % 2 == 0) begin
                chk("t2_wr",   64'(a_wr), 64'h1);
                chk("t2_idx",  64'({a_e, a_y, a_x}), 64'(idx_of(k)));
                chk("t2_data", a_mdata, 64'h20 + 64'(k));
                k = k + 1;
            end else begin
                chk("t2_stall_wr",   64'(a_wr), 64'h0);
                chk("t2_stall_idx",  64'({a_e, a_y, a_x}), 64'(idx_of(k - 1)));
                chk("t2_stall_data", a_mdata, 64'h20 + 64'(k - 1));
            end
        end
        chk("t2_done", 64'(a_done), 64'h1);
        step();
        chk("t2_nwr", 64'(a_wr_n - base), 64'd8);

        // start re-asserted during LOAD and during DONE is ignored.
        base = a_wr_n; dbase = a_done_n;
        a_start = 1'b1; step(); a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data  = 64'h30 + 64'(i);
            a_start = (i == 4);
            step();
        end
        a_start = 1'b0; a_valid = 1'b0;
        step();
        chk("t3_done", 64'(a_done), 64'h1);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("t3_idle_busy",  64'(a_busy), 64'h0);
        chk("t3_idle_ready", 64'(a_ready), 64'h0);
        step();
        step();
        chk("t3_still_idle", 64'(a_ready), 64'h0);
        chk("t3_nwr",   64'(a_wr_n - base), 64'd8);
        chk("t3_ndone", 64'(a_done_n - dbase), 64'd1);
        for (int j = 0; j < 8; j++) begin
            chk("t3_log_idx",  64'(a_idx_log[base + j]), 64'(idx_of(j)));
            chk("t3_log_data", a_dat_log[base + j], 64'h30 + 64'(j));
        end

        // Reset in the middle of a load.
        base = a_wr_n;
        a_start = 1'b1; step(); a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 64'h40 + 64'(i);
            step();
        end
        a_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",  64'(a_busy), 64'h0);
        chk("t4_rst_ready", 64'(a_ready), 64'h0);
        chk("t4_rst_wr",    64'(a_wr), 64'h0);
        chk("t4_rst_idx",   64'({a_e, a_y, a_x}), 64'h0);
        chk("t4_rst_data",  a_mdata, 64'h0);
        step();
        step();
        rst_n = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_noload_ready", 64'(a_ready), 64'h0);
            chk("t4_noload_wr",    64'(a_wr), 64'h0);
        end
        chk("t4_nwr", 64'(a_wr_n - base), 64'd3);
        a_valid = 1'b0;
        a_start = 1'b1; step(); a_start = 1'b0;
        a_valid = 1'b1; a_data = 64'h50;
        step();
        a_valid = 1'b0;
        chk("t4_restart_wr",   64'(a_wr), 64'h1);
        chk("t4_restart_idx",  64'({a_e, a_y, a_x}), 64'h0);
        chk("t4_restart_data", a_mdata, 64'h50);
        do_reset();

        // Single-word configuration.
        base = b_wr_n;
        b_start = 1'b1; step(); b_start = 1'b0;
        chk("t5_ready", 64'(b_ready), 64'h1);
        b_valid = 1'b1; b_data = 64'hABCD;
        step();
        chk("t5_wr",    64'(b_wr), 64'h1);
        chk("t5_idx",   64'({b_e, b_y, b_x}), 64'h0);
        chk("t5_data",  b_mdata, 64'hABCD);
        chk("t5_flush_ready", 64'(b_ready), 64'h0);
        b_data = 64'h1234;
        step();
        chk("t5_done",       64'(b_done), 64'h1);
        chk("t5_done_wr",    64'(b_wr), 64'h0);
        chk("t5_done_ready", 64'(b_ready), 64'h0);
        step();
        chk("t5_idle_ready", 64'(b_ready), 64'h0);
        chk("t5_idle_wr",    64'(b_wr), 64'h0);
        step();
        b_valid = 1'b0;
        chk("t5_nwr",   64'(b_wr_n - base), 64'd1);
        chk("t5_mdata", b_mdata, 64'hABCD);

`ifdef ACT_LOADER_ABORT_EN
        // Abort after five accepted words.
        base = a_wr_n; dbase = a_done_n;
        a_start = 1'b1; step(); a_start = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_data = 64'h60 + 64'(i);
            step();
        end
        a_valid = 1'b0;
        a_abort = 1'b1;
        chk("t6_abort_cycle_wr", 64'(a_wr), 64'h1);
        step();
        a_abort = 1'b0;
        chk("t6_idle_busy",  64'(a_busy), 64'h0);
        chk("t6_idle_ready", 64'(a_ready), 64'h0);
        chk("t6_idle_wr",    64'(a_wr), 64'h0);
        step();
        step();
        chk("t6_nwr",   64'(a_wr_n - base), 64'd5);
        chk("t6_ndone", 64'(a_done_n - dbase), 64'd0);
        a_start = 1'b1; step(); a_start = 1'b0;
        a_valid = 1'b1; a_data = 64'h70;
        step();
        a_valid = 1'b0;
        chk("t6_restart_idx",  64'({a_e, a_y, a_x}), 64'h0);
        chk("t6_restart_data", a_mdata, 64'h70);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
